// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed 7-segment driver for a BCD adder result, with an error state
// that blinks "Er". All outputs are registered; reset is synchronous and active-low.
module bcd_display_mux #(
  parameter int REFRESH_CNT = 50000,
  parameter int BLINK_SLOTS = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] result,
  input  logic       out_of_range,
  output logic [1:0] an,
  output logic [6:0] seg
);

  // state    | meaning
  // ST_BLANK | display dark, nothing captured since clear/reset
  // ST_SHOW  | valid BCD result on the digits
  // ST_ERR   | illegal operand or result, blink "Er"
  typedef enum logic [1:0] {ST_BLANK, ST_SHOW, ST_ERR} state_t;

  localparam int CW = $clog2(REFRESH_CNT);
  localparam int BW = $clog2(BLINK_SLOTS + 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_refresh_cnt;
  logic          r_digit_sel;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_on;
  logic [7:0]    r_result;
  logic          r_oor;
  logic          w_wrap;
  logic          w_bad;
  logic          w_err_entry;
  logic          w_cap_valid;
  logic [1:0]    w_an;
  logic [6:0]    w_seg;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h40;
      4'd1:    f_seg = 7'h79;
      4'd2:    f_seg = 7'h24;
      4'd3:    f_seg = 7'h30;
      4'd4:    f_seg = 7'h19;
      4'd5:    f_seg = 7'h12;
      4'd6:    f_seg = 7'h02;
      4'd7:    f_seg = 7'h78;
      4'd8:    f_seg = 7'h00;
      4'd9:    f_seg = 7'h10;
      default: f_seg = 7'h7F;
    endcase
  endfunction

  assign w_wrap      = (r_refresh_cnt == CW'(REFRESH_CNT - 1));
  assign w_bad       = out_of_range | (result[7:5] != 3'b000) | (result[3:0] > 4'd9);
  assign w_err_entry = load & ~clear & w_bad;
  // SHOW is only entered with a legal capture; the guard keeps a corrupt capture dark
  assign w_cap_valid = ~r_oor & (r_result[7:5] == 3'b000) & (r_result[3:0] <= 4'd9);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_BLANK;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (clear)     w_next_state = ST_BLANK;
    else if (load) w_next_state = w_bad ? ST_ERR : ST_SHOW;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_refresh_cnt <= '0;
      r_digit_sel   <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_on    <= 1'b1;
      r_result      <= 8'h00;
      r_oor         <= 1'b0;
    end else begin
      r_refresh_cnt <= w_wrap ? '0 : r_refresh_cnt + CW'(1);
      if (w_wrap) r_digit_sel <= ~r_digit_sel;
      if (load && !clear) begin
        r_result <= result;
        r_oor    <= out_of_range;
      end
      if (w_err_entry) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (r_state == ST_ERR && w_wrap) begin
        if (r_blink_cnt == BW'(BLINK_SLOTS - 1)) begin
          r_blink_cnt <= '0;
          r_blink_on  <= ~r_blink_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  always_comb begin
    w_an  = 2'b11;
    w_seg = 7'h7F;
    case (r_state)
      ST_SHOW: begin
        if (w_cap_valid) begin
          if (!r_digit_sel) begin
            w_an  = 2'b10;
            w_seg = f_seg(r_result[3:0]);
          end else if (r_result[4]) begin
            w_an  = 2'b01;
            w_seg = 7'h79;
          end
        end
      end
      ST_ERR: begin
        if (r_blink_on) begin
          if (r_digit_sel) begin
            w_an  = 2'b01;
            w_seg = 7'h06;
          end else begin
            w_an  = 2'b10;
            w_seg = 7'h2F;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an  <= 2'b11;
      seg <= 7'h7F;
    end else begin
      an  <= w_an;
      seg <= w_seg;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux: a behavioural model pushes the expected
// {an,seg} for every edge into a queue, popped and checked just after that edge.
module tb_bcd_display_mux;
  localparam int R = 4;
  localparam int B = 2;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic       clear;
  logic [7:0] result;
  logic       out_of_range;
  logic [1:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [8:0] q_exp[$];
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int         m_cnt   = 0;
  int         m_bcnt  = 0;
  int         m_state = 0;
  bit         m_dsel  = 0;
  bit         m_bon   = 1;
  logic [7:0] m_res   = 8'h00;

  bcd_display_mux #(.REFRESH_CNT(R), .BLINK_SLOTS(B)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .clear(clear),
    .result(result), .out_of_range(out_of_range), .an(an), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic ld, input logic cl,
                      input logic [7:0] res, input logic oor);
    logic [8:0] exp_v;
    logic [8:0] got;
    bit         wrap;
    bit         bad;
    reset_n = rn; load = ld; clear = cl; result = res; out_of_range = oor;
    exp_v = {2'b11, 7'h7F};
    if (rn) begin
      if (m_state == 1) begin
        if (!m_dsel)      exp_v = {2'b10, seg_tab[m_res[3:0]]};
        else if (m_res[4]) exp_v = {2'b01, 7'h79};
      end else if (m_state == 2 && m_bon) begin
        exp_v = m_dsel ? {2'b01, 7'h06} : {2'b10, 7'h2F};
      end
    end
    q_exp.push_back(exp_v);
    if (!rn) begin
      m_state = 0; m_cnt = 0; m_dsel = 0; m_bcnt = 0; m_bon = 1; m_res = 8'h00;
    end else begin
      wrap  = (m_cnt == R - 1);
      m_cnt = wrap ? 0 : m_cnt + 1;
      if (wrap) m_dsel = !m_dsel;
      if (cl) begin
        m_state = 0;
      end else if (ld) begin
        m_res = res;
        bad   = oor || (res[7:5] != 3'b000) || (res[3:0] > 4'd9);
        if (bad) begin
          m_state = 2; m_bcnt = 0; m_bon = 1;
        end else begin
          m_state = 1;
        end
      end else if (m_state == 2 && wrap) begin
        m_bcnt++;
        if (m_bcnt == B) begin
          m_bcnt = 0;
          m_bon  = !m_bon;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    got = q_exp.pop_front();
    checks++;
    assert ({an, seg} === got)
    else begin
      errors++;
      $error("FAIL out cyc=%0d observed an=%b seg=%h expected an=%b seg=%h",
             cyc, an, seg, got[8:7], got[6:0]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic ld(input logic [7:0] res, input logic oor);
    step(1'b1, 1'b1, 1'b0, res, oor);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(12);
    ld(8'h17, 1'b0);
    idle(16);
    ld(8'h05, 1'b0);
    idle(12);
    ld(8'h42, 1'b1);
    idle(26);
    ld(8'h0C, 1'b0);
    idle(26);
    ld(8'h13, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b1, 8'h09, 1'b0);
    idle(5);
    ld(8'h09, 1'b0);
    idle(9);
    for (int d = 0; d < 10; d++) begin
      ld(8'(d), 1'b0);
      idle(4);
      ld(8'(8'h10 | d), 1'b0);
      idle(4);
    end
    ld(8'h28, 1'b0);
    idle(6);
    ld(8'h00, 1'b1);
    idle(12);
    ld(8'h19, 1'b0);
    idle(8);
    for (int i = 0; i < 5; i++) ld(8'(8'h11 + i), 1'b0);
    idle(6);
    for (int i = 0; i < 5; i++) ld(8'hFF, 1'b1);
    idle(20);
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    idle(5);
    ld(8'h08, 1'b1);
    idle(5);
    step(1'b0, 1'b1, 1'b1, 8'h07, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    ld(8'h00, 1'b0);
    idle(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
